dht11_responder: RTL and testbench

- Emulates the slave (sensor) end of the DHT11 single-wire protocol.
- Detects a host start pulse on the shared open-drain line and answers with the standard response preamble plus a 40-bit frame built from register inputs.
- Used in simulation and on-board loopback to exercise the DHT11 reader in the measurement path without a physical sensor.
- Drives the line only low (open-drain); the top level converts dht_oe into the tri-state pad.

---
 rtl/dht11_responder.sv | 157 +++++++++++++++
 tb/tb_dht11_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: waits for a host start pulse, then answers with the
// response preamble and a 40-bit humidity/temperature frame on an open-drain line.
module dht11_responder #(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned RESP_LOW_US   = 80,
    parameter int unsigned RESP_HIGH_US  = 80,
    parameter int unsigned BIT_LOW_US    = 50,
    parameter int unsigned BIT0_HIGH_US  = 26,
    parameter int unsigned BIT1_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned START_CYC = START_MIN_US  * CYCLES_PER_US;
    localparam int unsigned DLY_CYC   = RESP_DELAY_US * CYCLES_PER_US;
    localparam int unsigned RLO_CYC   = RESP_LOW_US   * CYCLES_PER_US;
    localparam int unsigned RHI_CYC   = RESP_HIGH_US  * CYCLES_PER_US;
    localparam int unsigned BLO_CYC   = BIT_LOW_US    * CYCLES_PER_US;
    localparam int unsigned B0_CYC    = BIT0_HIGH_US  * CYCLES_PER_US;
    localparam int unsigned B1_CYC    = BIT1_HIGH_US  * CYCLES_PER_US;
    localparam int unsigned MAX_CYC   = max_u(START_CYC, max_u(max_u(DLY_CYC, RLO_CYC),
                                        max_u(max_u(RHI_CYC, BLO_CYC), max_u(B0_CYC, B1_CYC))));
    localparam int unsigned TW        = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] C_START_M1 = TW'(START_CYC - 1);
    localparam logic [TW-1:0] C_DLY      = TW'(DLY_CYC);
    localparam logic [TW-1:0] C_RLO      = TW'(RLO_CYC);
    localparam logic [TW-1:0] C_RHI      = TW'(RHI_CYC);
    localparam logic [TW-1:0] C_BLO      = TW'(BLO_CYC);
    localparam logic [TW-1:0] C_B0       = TW'(B0_CYC);
    localparam logic [TW-1:0] C_B1       = TW'(B1_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_RESP_DLY, S_RESP_LO, S_RESP_HI, S_BIT_LO, S_BIT_HI, S_END_LO
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sync1, r_sync2;
    logic          r_armed;
    logic [TW-1:0] r_timer;
    logic [5:0]    r_bit_idx;
    logic [39:0]   r_frame;
    logic          r_oe, r_busy, r_done;
    logic [7:0]    r_frame_cnt;

    logic          w_ls;
    logic [TW-1:0] w_phase_len;
    logic          w_phase_last;
    logic          w_accept;
    logic          w_frame_end;
    logic [7:0]    w_chk;

    assign w_ls        = r_sync2;
    assign w_chk       = hum_int + hum_dec + temp_int + temp_dec;
    assign w_accept    = (r_state == S_HOST_LOW) && (w_state_nxt == S_RESP_DLY);
    assign w_frame_end = (r_state == S_END_LO) && w_phase_last;

    always_comb begin
        w_phase_len = '0;
        case (r_state)
            S_RESP_DLY: w_phase_len = C_DLY;
            S_RESP_LO:  w_phase_len = C_RLO;
            S_RESP_HI:  w_phase_len = C_RHI;
            S_BIT_LO:   w_phase_len = C_BLO;
            S_BIT_HI:   w_phase_len = r_frame[r_bit_idx] ? C_B1 : C_B0;
            S_END_LO:   w_phase_len = C_BLO;
            default:    w_phase_len = '0;
        endcase
    end

    assign w_phase_last = (r_timer == w_phase_len - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (r_armed && !w_ls) w_state_nxt = S_HOST_LOW;
            S_HOST_LOW: if (w_ls) w_state_nxt = (r_timer >= C_START_M1) ? S_RESP_DLY : S_IDLE;
            S_RESP_DLY: if (w_phase_last) w_state_nxt = S_RESP_LO;
            S_RESP_LO:  if (w_phase_last) w_state_nxt = S_RESP_HI;
            S_RESP_HI:  if (w_phase_last) w_state_nxt = S_BIT_LO;
            S_BIT_LO:   if (w_phase_last) w_state_nxt = S_BIT_HI;
            S_BIT_HI:   if (w_phase_last) w_state_nxt = (r_bit_idx == 6'd0) ? S_END_LO : S_BIT_LO;
            S_END_LO:   if (w_phase_last) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_armed     <= 1'b0;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_frame     <= '0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sync1 <= dht_in;
            r_sync2 <= r_sync1;

            // The line must be seen high in IDLE before another start is accepted,
            // so a host still holding low after END_LO cannot retrigger a frame.
            if (r_state == S_END_LO)
                r_armed <= 1'b0;
            else if (r_state == S_IDLE && w_ls)
                r_armed <= 1'b1;

            if (w_state_nxt != r_state || r_state == S_IDLE)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 1'b1;

            if (w_accept) begin
                r_frame   <= {hum_int, hum_dec, temp_int, temp_dec, w_chk};
                r_bit_idx <= 6'd39;
            end else if (r_state == S_BIT_HI && w_phase_last && r_bit_idx != 6'd0) begin
                r_bit_idx <= r_bit_idx - 6'd1;
            end

            r_oe   <= (w_state_nxt == S_RESP_LO) || (w_state_nxt == S_BIT_LO) ||
                      (w_state_nxt == S_END_LO);
            r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HOST_LOW);
            r_done <= w_frame_end;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign dht_oe    = r_oe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model drives start pulses on a wired-AND line
// and decodes the returned waveform against frames computed from the payload bytes.
module tb_dht11_responder;

    localparam int unsigned CPU      = 1;
    localparam int unsigned START_US = 12;
    localparam int unsigned DLY_US   = 3;
    localparam int unsigned RLO_US   = 4;
    localparam int unsigned RHI_US   = 5;
    localparam int unsigned BLO_US   = 2;
    localparam int unsigned B0_US    = 1;
    localparam int unsigned B1_US    = 3;

    localparam int START_C = START_US * CPU;
    localparam int DLY_C   = DLY_US * CPU;
    localparam int RLO_C   = RLO_US * CPU;
    localparam int RHI_C   = RHI_US * CPU;
    localparam int BLO_C   = BLO_US * CPU;
    localparam int B0_C    = B0_US * CPU;
    localparam int B1_C    = B1_US * CPU;
    localparam int HOLD_C  = START_C + 4;
    localparam int LIMIT   = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       host;
    logic       line;
    logic       dht_oe;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       busy, done;
    logic [7:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    assign line = host & ~dht_oe;

    always #5 clk = ~clk;

    dht11_responder #(
        .CYCLES_PER_US(CPU),
        .START_MIN_US (START_US),
        .RESP_DELAY_US(DLY_US),
        .RESP_LOW_US  (RLO_US),
        .RESP_HIGH_US (RHI_US),
        .BIT_LOW_US   (BLO_US),
        .BIT0_HIGH_US (B0_US),
        .BIT1_HIGH_US (B1_US)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dht_in   (line),
        .dht_oe   (dht_oe),
        .hum_int  (hum_int),
        .hum_dec  (hum_dec),
        .temp_int (temp_int),
        .temp_dec (temp_dec),
        .busy     (busy),
        .done     (done),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive negedge samples at level lvl; returns at the first other sample.
    task automatic count_run(input logic lvl, output int n);
        n = 0;
        while (dht_oe === lvl && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
        int s;
        s = int'(a) + int'(b) + int'(c) + int'(d);
        return {a, b, c, d, 8'(s % 256)};
    endfunction

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input int low_len, input int change_at,
                             input logic [7:0] new_ti, input int rst_at, input bit hold_after);
        logic [39:0] exp_f;
        logic [39:0] got_f;
        int          n;
        bit          aborted;
        bit          seen;
        exp_f    = model_frame(a, b, c, d);
        hum_int  = a;
        hum_dec  = b;
        temp_int = c;
        temp_dec = d;
        host = 1'b0;
        repeat (low_len) @(negedge clk);
        host = 1'b1;
        @(negedge clk);
        // Release reaches the FSM after the 2-stage synchronizer plus its own register.
        count_run(1'b0, n); check("resp_delay", n, 64'(2 + DLY_C));
        check("busy_rise", busy, 1);
        count_run(1'b1, n); check("resp_low", n, 64'(RLO_C));
        count_run(1'b0, n); check("resp_high", n, 64'(RHI_C));
        got_f   = '0;
        aborted = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == change_at) temp_int = new_ti;
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                exp_cnt = 0;
                check("rst_oe", dht_oe, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_cnt", frame_cnt, 0);
                seen = 1'b0;
                repeat (5) begin @(negedge clk); if (done !== 1'b0 || dht_oe !== 1'b0) seen = 1'b1; end
                rst = 1'b1;
                repeat (8) begin @(negedge clk); if (done !== 1'b0 || dht_oe !== 1'b0) seen = 1'b1; end
                check("rst_quiet", seen, 0);
                aborted = 1'b1;
                break;
            end
            count_run(1'b1, n); check("bit_low", n, 64'(BLO_C));
            count_run(1'b0, n); check("bit_high", n, 64'(exp_f[39-k] ? B1_C : B0_C));
            got_f = {got_f[38:0], (n > (B0_C + B1_C) / 2)};
        end
        if (!aborted) begin
            check("frame", got_f, exp_f);
            count_run(1'b1, n); check("end_low", n, 64'(BLO_C));
            exp_cnt = (exp_cnt + 1) % 256;
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
            check("frame_cnt", frame_cnt, 64'(exp_cnt));
            if (hold_after) host = 1'b0;
            @(negedge clk);
            check("done_width", done, 0);
            if (hold_after) begin
                seen = 1'b0;
                repeat (HOLD_C) begin @(negedge clk); if (dht_oe !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
                check("no_restart", seen, 0);
                host = 1'b1;
            end
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        bit seen_oe;
        bit seen_busy;
        rst = 1'b1;
        host = 1'b1;
        hum_int = '0; hum_dec = '0; temp_int = '0; temp_dec = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oe", dht_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cnt", frame_cnt, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal frame at exactly the minimum start length.
        run_frame(8'h37, 8'h00, 8'h18, 8'h03, START_C, -1, 8'h00, -1, 1'b0);

        // Start pulse one cycle short of the minimum is ignored.
        host = 1'b0;
        repeat (START_C - 1) @(negedge clk);
        host = 1'b1;
        seen_oe = 1'b0; seen_busy = 1'b0;
        repeat (40) begin @(negedge clk); if (dht_oe !== 1'b0) seen_oe = 1'b1; if (busy !== 1'b0) seen_busy = 1'b1; end
        check("short_oe", seen_oe, 0);
        check("short_busy", seen_busy, 0);
        check("short_cnt", frame_cnt, 64'(exp_cnt));

        run_frame(8'hFF, 8'hFF, 8'h01, 8'h02, START_C + 5, -1, 8'h00, -1, 1'b0);

        // Input change during bit 10 only affects the following frame.
        run_frame(8'h37, 8'h00, 8'h18, 8'h03, START_C + 3, 10, 8'h20, -1, 1'b0);
        run_frame(8'h37, 8'h00, 8'h20, 8'h03, START_C, -1, 8'h00, -1, 1'b0);

        repeat (3) run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                             START_C + int'($urandom_range(0, 10)), -1, 8'h00, -1, 1'b0);

        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), START_C, -1, 8'h00, 5, 1'b0);

        for (int i = 0; i < 256; i++) begin
            if (i < 4)
                run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                          START_C + int'($urandom_range(0, 4)), -1, 8'h00, -1, 1'b1);
            else
                run_frame(8'h00, 8'h00, 8'h00, 8'h00, START_C, -1, 8'h00, -1, 1'b1);
        end
        check("wrap_cnt", frame_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
